// File: rtl/problema1_avalon_master.sv
// Avalon-MM initiator: turns a valid/ready command stream into single read or
// write transfers and returns one response (read data or timeout error) per command.
module problema1_avalon_master #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  // state | meaning
  // IDLE  | cmd_ready high, waiting for a command
  // BUS   | strobes asserted, waiting for waitrequest low or timeout
  // RESP  | strobes released, rsp_valid pulses for one cycle
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      wait_cnt       <= '0;
      rsp_valid      <= 1'b0;
      rsp_readdata   <= '0;
      rsp_error      <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            avm_address    <= cmd_address;
            avm_writedata  <= cmd_writedata;
            avm_chipselect <= 1'b1;
            avm_write_n    <= ~cmd_write;
            avm_read_n     <= cmd_write;
            wait_cnt       <= '0;
            cmd_ready      <= 1'b0;
            state          <= BUS;
          end
        end
        BUS: begin
          if (!avm_waitrequest || (wait_cnt == CNT_LAST)) begin
            // avm_write_n still reflects the transfer type until this edge
            rsp_readdata   <= (!avm_waitrequest && avm_write_n) ? avm_readdata : '0;
            rsp_error      <= avm_waitrequest;
            rsp_valid      <= 1'b1;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            state          <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
